// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU: op encoding and FSM states.
package serial_alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_XOR  = 2'b00,
    OP_NAND = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_alu_if.sv
// Operand/result handshake bundle for serial_alu.
// Flag outputs exist only when SERIAL_ALU_FLAGS_EN is defined.
interface serial_alu_if
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_e              op;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
`ifdef SERIAL_ALU_FLAGS_EN
  logic             zero_flag;
  logic             ovf_flag;
`endif

  modport master (
    output start_valid, a, b, op, res_ready,
`ifdef SERIAL_ALU_FLAGS_EN
    input  zero_flag, ovf_flag,
`endif
    input  start_ready, res_valid, result, carry_out
  );

  modport slave (
    input  start_valid, a, b, op, res_ready,
`ifdef SERIAL_ALU_FLAGS_EN
    output zero_flag, ovf_flag,
`endif
    output start_ready, res_valid, result, carry_out
  );
endinterface

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: XOR / NAND / full adder / full subtractor.
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  op_e  op,
  output logic y,
  output logic cout
);
  always_comb begin
    y    = 1'b0;
    cout = 1'b0;
    unique case (op)
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_ADD: begin
        y    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
      OP_SUB: begin
        // cin/cout carry the borrow here
        y    = a ^ b ^ cin;
        cout = (~a & b) | (~(a ^ b) & cin);
      end
    endcase
  end
endmodule

// File: rtl/serial_alu.sv
// Bit-serial WIDTH-bit ALU, LSB first, with valid/ready on both sides.
// Optional zero/overflow flags via SERIAL_ALU_FLAGS_EN.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  serial_alu_if.slave  bus
);
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  op_e              r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             w_y;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;
  logic             w_done;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept   = (r_state == S_IDLE) && bus.start_valid;
  assign w_last     = (r_state == S_RUN) && (r_cnt == LAST);
  assign w_done     = (r_state == S_DONE);
  assign w_res_next = {w_y, r_res_sh[WIDTH-1:1]};

  alu_bit_slice u_slice (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .op   (r_op),
    .y    (w_y),
    .cout (w_cout)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start_valid) w_next = S_RUN;
      S_RUN:   if (w_last)          w_next = S_DONE;
      S_DONE:  if (bus.res_ready)   w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_op     <= OP_XOR;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= bus.a;
      r_b_sh   <= bus.b;
      r_res_sh <= '0;
      r_op     <= bus.op;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_res_sh <= w_res_next;
      r_cnt    <= r_cnt + CW'(1);
      r_carry  <= w_cout;
    end
  end

  assign bus.start_ready = (r_state == S_IDLE);
  assign bus.res_valid   = w_done;
  assign bus.result      = w_done ? r_res_sh : '0;
  assign bus.carry_out   = w_done & r_carry;

`ifdef SERIAL_ALU_FLAGS_EN
  logic r_zero;
  logic r_ovf;

  // Signed overflow = carry/borrow into MSB differs from carry/borrow out of MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_zero <= (w_res_next == '0);
      r_ovf  <= ((r_op == OP_ADD) || (r_op == OP_SUB)) && (r_carry ^ w_cout);
    end
  end

  assign bus.zero_flag = w_done & r_zero;
  assign bus.ovf_flag  = w_done & r_ovf;
`endif
endmodule
